pong_match_ctrl: RTL

//  Match sequencer for the Pong datapath: derives a one-cycle frame tick from VGA vs and owns the

---
 rtl/pong_pkg.sv | 23 ++
 rtl/frame_tick_gen.sv | 27 ++
 rtl/pong_match_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE_WAIT  = 3'd1,
    PLAY        = 3'd2,
    POINT_PAUSE = 3'd3,
    GAME_OVER   = 3'd4
  } pong_state_t;

  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_ENTER = 8'h28;

  // Wide enough for both the point pause and the auto-serve timeout.
  localparam int unsigned FRAME_CNT_W = 8;

  // Saturating single-digit BCD increment.
  function automatic logic [3:0] bcd_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v < lim) ? v + 4'd1 : v;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronizes the asynchronous VGA vs and emits a one-cycle pulse on its rising edge.
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vs,
  output logic tick
);

  logic vs_meta;
  logic vs_sync;
  logic vs_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
      tick    <= 1'b0;
    end else begin
      vs_meta <= vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
      tick    <= vs_sync & ~vs_prev;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/pause/game-over control, BCD scores and frame tick.
// Optional auto-serve after a frame timeout is enabled by defining PONG_AUTO_SERVE_EN.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 9,
  parameter int unsigned PAUSE_FRAMES  = 60,
`ifdef PONG_AUTO_SERVE_EN
  parameter int unsigned SERVE_TIMEOUT = 180,
`endif
  parameter logic [7:0]  KEY_SERVE     = KC_SPACE,
  parameter logic [7:0]  KEY_NEW       = KC_ENTER
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       frame_tick,
  output logic       ball_run,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  localparam logic [3:0]             WIN_LIM   = 4'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] PAUSE_LIM = FRAME_CNT_W'(PAUSE_FRAMES);
`ifdef PONG_AUTO_SERVE_EN
  localparam logic [FRAME_CNT_W-1:0] SERVE_LIM = FRAME_CNT_W'(SERVE_TIMEOUT);
`endif

  pong_state_t            state_q;
  logic [FRAME_CNT_W-1:0] cnt_q;
  logic [FRAME_CNT_W-1:0] cnt_inc;
  logic [3:0]             score_l_inc;
  logic [3:0]             score_r_inc;

  frame_tick_gen u_frame_tick_gen (
    .clk   (Clk),
    .reset (Reset),
    .vs    (vs),
    .tick  (frame_tick)
  );

  always_comb begin
    cnt_inc     = cnt_q + 1'b1;
    score_l_inc = bcd_inc(score_l, WIN_LIM);
    score_r_inc = bcd_inc(score_r, WIN_LIM);
  end

  assign state = state_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      ball_reset <= 1'b1;
      ball_run   <= 1'b0;
      serve_dir  <= 1'b1;
      game_over  <= 1'b0;
      winner     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (keycode == KEY_NEW) begin
            score_l <= 4'd0;
            score_r <= 4'd0;
            cnt_q   <= '0;
            state_q <= SERVE_WAIT;
          end
        end

        SERVE_WAIT: begin
`ifdef PONG_AUTO_SERVE_EN
          if (frame_tick) cnt_q <= cnt_inc;
          if (keycode == KEY_SERVE || (frame_tick && cnt_inc == SERVE_LIM)) begin
`else
          if (keycode == KEY_SERVE) begin
`endif
            ball_reset <= 1'b0;
            ball_run   <= 1'b1;
            state_q    <= PLAY;
          end
        end

        PLAY: begin
          if (miss_left || miss_right) begin
            ball_reset <= 1'b1;
            ball_run   <= 1'b0;
            cnt_q      <= '0;
            state_q    <= POINT_PAUSE;
            // A simultaneous double miss is a void point.
            if (miss_left && !miss_right) begin
              score_r   <= score_r_inc;
              serve_dir <= 1'b0;
              if (score_r_inc == WIN_LIM) begin
                game_over <= 1'b1;
                winner    <= 1'b1;
                state_q   <= GAME_OVER;
              end
            end else if (miss_right && !miss_left) begin
              score_l   <= score_l_inc;
              serve_dir <= 1'b1;
              if (score_l_inc == WIN_LIM) begin
                game_over <= 1'b1;
                winner    <= 1'b0;
                state_q   <= GAME_OVER;
              end
            end
          end
        end

        POINT_PAUSE: begin
          if (frame_tick) begin
            if (cnt_inc == PAUSE_LIM) begin
              cnt_q   <= '0;
              state_q <= SERVE_WAIT;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        GAME_OVER: begin
          if (keycode == KEY_NEW) begin
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= SERVE_WAIT;
          end
        end

        default: begin
          state_q    <= IDLE;
          ball_reset <= 1'b1;
          ball_run   <= 1'b0;
          game_over  <= 1'b0;
        end
      endcase
    end
  end

endmodule
